// File: rtl/mem_march_bist.sv
// March C- built-in self-test controller for a single-port synchronous memory.
// Ports: clk, rst_n (async active-low); start -> busy/done/fail/fail_addr/fail_elem;
// memory side: mem_read, mem_wr, mem_addr, mem_din out; mem_dout in (registered read).
module mem_march_bist #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic              mem_read,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        elem_q, elem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              phase_q, phase_d;
    logic              seq_end_q, seq_end_d;
    logic              cmp_vld_q, cmp_vld_d;
    logic [DATA_W-1:0] cmp_exp_q, cmp_exp_d;
    logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
    logic [2:0]        cmp_elem_q, cmp_elem_d;
    logic              fail_q, fail_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]        fail_elem_q, fail_elem_d;

    logic op_active;
    logic rd_op;
    logic wr_op;
    logic last_of_addr;
    logic desc;
    logic rd_ones;
    logic wr_ones;
    logic addr_end;

    // Op decode. phase 0 is the read, phase 1 the write of an r/w element;
    // E0 is write-only and E5 read-only, so their phase stays 0.
    always_comb begin
        op_active    = (state_q == S_RUN) && !seq_end_q;
        rd_op        = op_active && (elem_q != 3'd0) && !phase_q;
        wr_op        = op_active && (elem_q != 3'd5) &&
                       ((elem_q == 3'd0) || phase_q);
        last_of_addr = (elem_q == 3'd0) || (elem_q == 3'd5) || phase_q;
        desc         = (elem_q == 3'd3) || (elem_q == 3'd4);
        rd_ones      = (elem_q == 3'd2) || (elem_q == 3'd4);
        wr_ones      = (elem_q == 3'd1) || (elem_q == 3'd3);
        addr_end     = desc ? (addr_q == '0) : (addr_q == '1);
    end

    always_comb begin
        mem_read  = rd_op;
        mem_wr    = wr_op;
        mem_addr  = op_active ? addr_q : '0;
        mem_din   = (wr_op && wr_ones) ? '1 : '0;
        busy      = (state_q == S_RUN);
        done      = (state_q == S_DONE);
        fail      = fail_q;
        fail_addr = fail_addr_q;
        fail_elem = fail_elem_q;
    end

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        addr_d      = addr_q;
        phase_d     = phase_q;
        seq_end_d   = seq_end_q;
        cmp_vld_d   = 1'b0;
        cmp_exp_d   = cmp_exp_q;
        cmp_addr_d  = cmp_addr_q;
        cmp_elem_d  = cmp_elem_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_RUN;
                    elem_d      = 3'd0;
                    addr_d      = '0;
                    phase_d     = 1'b0;
                    seq_end_d   = 1'b0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_elem_d = 3'd0;
                end
            end
            S_RUN: begin
                if (cmp_vld_q && (mem_dout != cmp_exp_q)) begin
                    state_d     = S_DONE;
                    fail_d      = 1'b1;
                    fail_addr_d = cmp_addr_q;
                    fail_elem_d = cmp_elem_q;
                end else if (seq_end_q) begin
                    // Last op issued one cycle ago; its compare was just done.
                    state_d = S_DONE;
                end else begin
                    cmp_vld_d  = rd_op;
                    cmp_exp_d  = rd_ones ? '1 : '0;
                    cmp_addr_d = addr_q;
                    cmp_elem_d = elem_q;
                    if (!last_of_addr) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (addr_end) begin
                            if (elem_q == 3'd5) begin
                                seq_end_d = 1'b1;
                            end else begin
                                elem_d = elem_q + 3'd1;
                                // E3 and E4 sweep downward from the top.
                                addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ?
                                         '1 : '0;
                            end
                        end else begin
                            addr_d = desc ? addr_q - 1'b1 : addr_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            elem_q      <= 3'd0;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            seq_end_q   <= 1'b0;
            cmp_vld_q   <= 1'b0;
            cmp_exp_q   <= '0;
            cmp_addr_q  <= '0;
            cmp_elem_q  <= 3'd0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            phase_q     <= phase_d;
            seq_end_q   <= seq_end_d;
            cmp_vld_q   <= cmp_vld_d;
            cmp_exp_q   <= cmp_exp_d;
            cmp_addr_q  <= cmp_addr_d;
            cmp_elem_q  <= cmp_elem_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
        end
    end

endmodule
